// File: rtl/disp_scan4_if.sv
// Bus between a display-value source and the 4-digit scan controller.
// The source (master) supplies the packed-BCD value, its load strobe and
// the whole-display blank request; the scanner (slave) returns the
// registered decoder-facing outputs and the frame-wrap pulse.
interface disp_scan4_if;
  logic        load;
  logic [15:0] value;
  logic        blank_all;
  logic [3:0]  code;
  logic        BL_L;
  logic [3:0]  dig_sel;
  logic        frame_done;

  modport master (
    output load,
    output value,
    output blank_all,
    input  code,
    input  BL_L,
    input  dig_sel,
    input  frame_done
  );

  modport slave (
    input  load,
    input  value,
    input  blank_all,
    output code,
    output BL_L,
    output dig_sel,
    output frame_done
  );
endinterface

// File: rtl/disp_scan4.sv
// Time-multiplexed scan controller for a 4-digit 7-segment display.
// Holds a shadow copy of the packed-BCD value, steps a one-hot digit
// select every SCAN_DIV clocks, and feeds the downstream BCD decoder the
// selected nibble plus an active-low blank (leading-zero and whole-display
// blanking). All outputs come straight from flops.
module disp_scan4 #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter bit          LZ_BLANK = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  disp_scan4_if.slave   bus
);

  // A one-cycle slot still needs a 1-bit counter that simply stays at 0.
  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  logic [15:0]      shadow;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;

  logic [3:0]       code_q;
  logic             bl_l_q;
  logic [3:0]       dig_sel_q;
  logic             frame_done_q;

  logic             tick;
  logic [CNT_W-1:0] cnt_next;
  logic [1:0]       idx_next;
  logic [3:0]       dig_sel_next;
  logic [3:0]       code_next;
  logic             bl_l_next;
  logic             frame_done_next;

  // Nibble i of the packed-BCD word; digit 0 is the least significant.
  function automatic logic [3:0] nibble_of(input logic [15:0] word,
                                           input logic [1:0]  sel);
    logic [3:0] n;
    case (sel)
      2'd0:    n = word[3:0];
      2'd1:    n = word[7:4];
      2'd2:    n = word[11:8];
      default: n = word[15:12];
    endcase
    return n;
  endfunction

  // One-hot, active-high digit enable for a digit index.
  function automatic logic [3:0] onehot_of(input logic [1:0] sel);
    logic [3:0] oh;
    case (sel)
      2'd0:    oh = 4'b0001;
      2'd1:    oh = 4'b0010;
      2'd2:    oh = 4'b0100;
      default: oh = 4'b1000;
    endcase
    return oh;
  endfunction

  // Leading-zero test: digit i>0 is shown only if it or some higher
  // nibble is non-zero. Codes above 9 are non-zero and pass through so the
  // decoder can deal with them. Digit 0 is always shown.
  function automatic logic lz_show(input logic [15:0] word,
                                   input logic [1:0]  sel);
    logic show;
    case (sel)
      2'd0:    show = 1'b1;
      2'd1:    show = |word[15:4];
      2'd2:    show = |word[15:8];
      default: show = |word[15:12];
    endcase
    return show;
  endfunction

  // Prescaler, digit advance and blank computation for the coming edge.
  // Code uses the shadow as it stands before any load on the same edge, so
  // a freshly loaded nibble waits for the next visit to its digit.
  always_comb begin
    tick            = (cnt == CNT_MAX);
    cnt_next        = cnt + 1'b1;
    idx_next        = idx;
    dig_sel_next    = dig_sel_q;
    code_next       = code_q;
    bl_l_next       = 1'b0;
    frame_done_next = 1'b0;

    if (tick) begin
      cnt_next        = '0;
      idx_next        = idx + 2'd1;
      dig_sel_next    = onehot_of(idx + 2'd1);
      code_next       = nibble_of(shadow, idx + 2'd1);
      frame_done_next = (idx == 2'd3);
    end

    if (LZ_BLANK) begin
      bl_l_next = !bus.blank_all && lz_show(shadow, idx_next);
    end else begin
      bl_l_next = !bus.blank_all;
    end
  end

  // State and output registers; reset wins over load and blank requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow       <= '0;
      cnt          <= '0;
      idx          <= 2'd0;
      code_q       <= 4'h0;
      bl_l_q       <= 1'b0;
      dig_sel_q    <= 4'b0001;
      frame_done_q <= 1'b0;
    end else begin
      if (bus.load) begin
        shadow <= bus.value;
      end
      cnt          <= cnt_next;
      idx          <= idx_next;
      code_q       <= code_next;
      bl_l_q       <= bl_l_next;
      dig_sel_q    <= dig_sel_next;
      frame_done_q <= frame_done_next;
    end
  end

  assign bus.code       = code_q;
  assign bus.BL_L       = bl_l_q;
  assign bus.dig_sel    = dig_sel_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_disp_scan4.sv
// Directed bench for disp_scan4: three instances share clock and reset
// (SCAN_DIV=4 with leading-zero blanking, SCAN_DIV=4 without, SCAN_DIV=1).
// Expected values are hand-derived from edge counts since reset release.
module tb_disp_scan4;

  logic clk;
  logic rst;
  int   c;
  int   n_cmp;
  int   n_fail;

  disp_scan4_if bus_main ();
  disp_scan4_if bus_nl ();
  disp_scan4_if bus_fast ();

  disp_scan4 #(.SCAN_DIV(4), .LZ_BLANK(1'b1)) dut_main (
    .clk (clk),
    .rst (rst),
    .bus (bus_main)
  );

  disp_scan4 #(.SCAN_DIV(4), .LZ_BLANK(1'b0)) dut_nl (
    .clk (clk),
    .rst (rst),
    .bus (bus_nl)
  );

  disp_scan4 #(.SCAN_DIV(1), .LZ_BLANK(1'b1)) dut_fast (
    .clk (clk),
    .rst (rst),
    .bus (bus_fast)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one edge and sample 1 unit later; c counts edges since release.
  task automatic step();
    @(posedge clk);
    #1;
    c++;
  endtask

  task automatic run_to(input int target);
    while (c < target) step();
  endtask

  task automatic drive(input logic l, input logic [15:0] v, input logic b);
    bus_main.load      = l;
    bus_main.value     = v;
    bus_main.blank_all = b;
    bus_nl.load        = l;
    bus_nl.value       = v;
    bus_nl.blank_all   = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 16'h0000, 1'b0);
    step();
    step();
    rst = 1'b0;
    c   = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus_main.dig_sel !== 4'b0001) begin n_fail++; $display("[TB] FAIL rst_dig_sel: got %b want 0001", bus_main.dig_sel); end
    n_cmp++; if (bus_main.code !== 4'h0) begin n_fail++; $display("[TB] FAIL rst_code: got %h want 0", bus_main.code); end
    n_cmp++; if (bus_main.BL_L !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_bl_l: got %b want 0", bus_main.BL_L); end
    n_cmp++; if (bus_main.frame_done !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_frame_done: got %b want 0", bus_main.frame_done); end
    n_cmp++; if (bus_fast.dig_sel !== 4'b0001) begin n_fail++; $display("[TB] FAIL rst_fast_dig_sel: got %b want 0001", bus_fast.dig_sel); end
  endtask

  task automatic test_scan_rate();
    logic [3:0] exp_sel;
    logic       exp_fd;
    do_reset();
    drive(1'b0, 16'h0000, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      step();
      n_cmp++; if (bus_main.dig_sel !== 4'b0001 || bus_main.code !== 4'h0 || bus_main.BL_L !== 1'b0 || bus_main.frame_done !== 1'b0) begin
        n_fail++; $display("[TB] FAIL pre_tick c=%0d: got sel=%b code=%h bl=%b fd=%b want 0001/0/0/0", c, bus_main.dig_sel, bus_main.code, bus_main.BL_L, bus_main.frame_done);
      end
    end
    drive(1'b0, 16'h0000, 1'b0);
    for (int k = 4; k <= 20; k++) begin
      step();
      exp_sel = 4'(1 << ((c / 4) % 4));
      exp_fd  = (c == 16);
      n_cmp++; if (bus_main.dig_sel !== exp_sel) begin n_fail++; $display("[TB] FAIL scan_dig_sel c=%0d: got %b want %b", c, bus_main.dig_sel, exp_sel); end
      n_cmp++; if (bus_main.frame_done !== exp_fd) begin n_fail++; $display("[TB] FAIL scan_frame_done c=%0d: got %b want %b", c, bus_main.frame_done, exp_fd); end
    end
  endtask

  task automatic test_leading_zero();
    logic [3:0] exp_sel [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] exp_code[4] = '{4'h4, 4'h0, 4'h0, 4'h5};
    logic       exp_bl  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic       exp_z_bl[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    drive(1'b1, 16'h0045, 1'b0);
    step();
    drive(1'b0, 16'h0045, 1'b0);
    for (int k = 0; k < 4; k++) begin
      run_to(4 * (k + 1));
      n_cmp++; if (bus_main.dig_sel !== exp_sel[k]) begin n_fail++; $display("[TB] FAIL lz_dig_sel c=%0d: got %b want %b", c, bus_main.dig_sel, exp_sel[k]); end
      n_cmp++; if (bus_main.code !== exp_code[k]) begin n_fail++; $display("[TB] FAIL lz_code c=%0d: got %h want %h", c, bus_main.code, exp_code[k]); end
      n_cmp++; if (bus_main.BL_L !== exp_bl[k]) begin n_fail++; $display("[TB] FAIL lz_bl_l c=%0d: got %b want %b", c, bus_main.BL_L, exp_bl[k]); end
      n_cmp++; if (bus_nl.code !== exp_code[k]) begin n_fail++; $display("[TB] FAIL nolz_code c=%0d: got %h want %h", c, bus_nl.code, exp_code[k]); end
      n_cmp++; if (bus_nl.BL_L !== 1'b1) begin n_fail++; $display("[TB] FAIL nolz_bl_l c=%0d: got %b want 1", c, bus_nl.BL_L); end
    end
    drive(1'b1, 16'h0000, 1'b0);
    step();
    drive(1'b0, 16'h0000, 1'b0);
    for (int k = 0; k < 4; k++) begin
      run_to(20 + 4 * k);
      n_cmp++; if (bus_main.code !== 4'h0) begin n_fail++; $display("[TB] FAIL zero_code c=%0d: got %h want 0", c, bus_main.code); end
      n_cmp++; if (bus_main.BL_L !== exp_z_bl[k]) begin n_fail++; $display("[TB] FAIL zero_bl_l c=%0d: got %b want %b", c, bus_main.BL_L, exp_z_bl[k]); end
    end
  endtask

  task automatic test_interior_zero();
    logic [3:0] exp_code[4] = '{4'h0, 4'h0, 4'h1, 4'h9};
    do_reset();
    drive(1'b1, 16'h1009, 1'b0);
    step();
    drive(1'b0, 16'h1009, 1'b0);
    for (int k = 0; k < 4; k++) begin
      run_to(4 * (k + 1));
      n_cmp++; if (bus_main.code !== exp_code[k]) begin n_fail++; $display("[TB] FAIL iz_code c=%0d: got %h want %h", c, bus_main.code, exp_code[k]); end
      n_cmp++; if (bus_main.BL_L !== 1'b1) begin n_fail++; $display("[TB] FAIL iz_bl_l c=%0d: got %b want 1", c, bus_main.BL_L); end
    end
  endtask

  task automatic test_load_tick();
    do_reset();
    drive(1'b1, 16'h1234, 1'b0);
    step();
    drive(1'b0, 16'h1234, 1'b0);
    run_to(19);
    drive(1'b1, 16'h5678, 1'b0);
    step();
    drive(1'b0, 16'h5678, 1'b0);
    n_cmp++; if (bus_main.dig_sel !== 4'b0010 || bus_main.code !== 4'h3) begin n_fail++; $display("[TB] FAIL lt_same_edge: got sel=%b code=%h want 0010/3", bus_main.dig_sel, bus_main.code); end
    run_to(23);
    n_cmp++; if (bus_main.code !== 4'h3) begin n_fail++; $display("[TB] FAIL lt_hold: got %h want 3", bus_main.code); end
    run_to(24);
    n_cmp++; if (bus_main.code !== 4'h6) begin n_fail++; $display("[TB] FAIL lt_idx2_new: got %h want 6", bus_main.code); end
    run_to(36);
    n_cmp++; if (bus_main.dig_sel !== 4'b0010 || bus_main.code !== 4'h7) begin n_fail++; $display("[TB] FAIL lt_idx1_new: got sel=%b code=%h want 0010/7", bus_main.dig_sel, bus_main.code); end
  endtask

  task automatic test_blank_all();
    do_reset();
    drive(1'b1, 16'h1234, 1'b0);
    step();
    drive(1'b0, 16'h1234, 1'b0);
    run_to(8);
    n_cmp++; if (bus_main.dig_sel !== 4'b0100 || bus_main.code !== 4'h2 || bus_main.BL_L !== 1'b1) begin
      n_fail++; $display("[TB] FAIL ba_before: got sel=%b code=%h bl=%b want 0100/2/1", bus_main.dig_sel, bus_main.code, bus_main.BL_L);
    end
    drive(1'b0, 16'h1234, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++; if (bus_main.BL_L !== 1'b0) begin n_fail++; $display("[TB] FAIL ba_blank c=%0d: got %b want 0", c, bus_main.BL_L); end
      n_cmp++; if (bus_main.dig_sel !== 4'b0100 || bus_main.code !== 4'h2) begin n_fail++; $display("[TB] FAIL ba_hold c=%0d: got sel=%b code=%h want 0100/2", c, bus_main.dig_sel, bus_main.code); end
    end
    drive(1'b0, 16'h1234, 1'b0);
    step();
    n_cmp++; if (bus_main.BL_L !== 1'b1) begin n_fail++; $display("[TB] FAIL ba_release: got %b want 1", bus_main.BL_L); end
  endtask

  task automatic test_midscan_reset();
    do_reset();
    drive(1'b1, 16'h1234, 1'b0);
    step();
    drive(1'b0, 16'h1234, 1'b1);
    run_to(8);
    n_cmp++; if (bus_main.dig_sel !== 4'b0100) begin n_fail++; $display("[TB] FAIL mr_pre_idx2: got %b want 0100", bus_main.dig_sel); end
    rst = 1'b1;
    drive(1'b1, 16'hFFFF, 1'b0);
    step();
    n_cmp++; if (bus_main.dig_sel !== 4'b0001 || bus_main.code !== 4'h0 || bus_main.BL_L !== 1'b0 || bus_main.frame_done !== 1'b0) begin
      n_fail++; $display("[TB] FAIL mr_state: got sel=%b code=%h bl=%b fd=%b want 0001/0/0/0", bus_main.dig_sel, bus_main.code, bus_main.BL_L, bus_main.frame_done);
    end
    rst = 1'b0;
    drive(1'b0, 16'h0000, 1'b0);
    c = 0;
    run_to(4);
    n_cmp++; if (bus_main.code !== 4'h0 || bus_main.BL_L !== 1'b0) begin n_fail++; $display("[TB] FAIL mr_shadow_idx1: got code=%h bl=%b want 0/0", bus_main.code, bus_main.BL_L); end
    run_to(12);
    n_cmp++; if (bus_main.code !== 4'h0 || bus_main.dig_sel !== 4'b1000) begin n_fail++; $display("[TB] FAIL mr_shadow_idx3: got code=%h sel=%b want 0/1000", bus_main.code, bus_main.dig_sel); end
  endtask

  task automatic test_fast_scan();
    logic [3:0] exp_sel;
    logic       exp_fd;
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      step();
      exp_sel = 4'(1 << (c % 4));
      exp_fd  = ((c % 4) == 0);
      n_cmp++; if (bus_fast.dig_sel !== exp_sel) begin n_fail++; $display("[TB] FAIL fast_dig_sel c=%0d: got %b want %b", c, bus_fast.dig_sel, exp_sel); end
      n_cmp++; if (bus_fast.frame_done !== exp_fd) begin n_fail++; $display("[TB] FAIL fast_frame_done c=%0d: got %b want %b", c, bus_fast.frame_done, exp_fd); end
    end
  endtask

  initial begin
    rst    = 1'b1;
    c      = 0;
    n_cmp  = 0;
    n_fail = 0;
    drive(1'b0, 16'h0000, 1'b0);
    bus_fast.load      = 1'b0;
    bus_fast.value     = 16'h0000;
    bus_fast.blank_all = 1'b0;
    $display("[TB] starting disp_scan4 directed tests");
    test_reset();
    test_scan_rate();
    test_leading_zero();
    test_interior_zero();
    test_load_tick();
    test_blank_all();
    test_midscan_reset();
    test_fast_scan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
